dmi_arb_mux: RTL and testbench
==============================

// Module: dmi_arb_mux
// PURPOSE
//   Arbitrates NumCh DMI masters onto one debug-module DMI port, single clock domain (downstream of CDCs).
//   Tracks outstanding requests in an in-order ID FIFO and routes each response to its issuing channel.
//   Successor to the single-channel DMI crossing: multi-channel, configurable depth, optional response timeout.
// PARAMETERS
//   NumCh          2     number of DMI master channels (>=1)
//   MaxOutstanding 4     ID FIFO depth = max in-flight requests (power of 2, >=1)
//   TimeoutCycles  1024  cycles before synthesised error response (DMI_ARB_TIMEOUT_EN only, >=2)
// PORTS
//   clk_i             in   1                  clock
//   rst_i             in   1                  reset, asynchronous, active-high
//   ch_req_i          in   NumCh x dmi_req_t  per-channel request
//   ch_req_valid_i    in   NumCh              per-channel request valid
//   ch_req_ready_o    out  NumCh              per-channel request ready
//   ch_resp_o         out  NumCh x dmi_resp_t per-channel response
//   ch_resp_valid_o   out  NumCh              per-channel response valid
//   ch_resp_ready_i   in   NumCh              per-channel response ready
//   core_dmi_req_o    out  dmi_req_t          request to debug module
//   core_dmi_valid_o  out  1                  request valid
//   core_dmi_ready_i  in   1                  request ready
//   core_dmi_resp_i   in   dmi_resp_t         response from debug module
//   core_dmi_valid_i  in   1                  response valid
//   core_dmi_ready_o  out  1                  response ready
//   outstanding_o     out  $clog2(MaxOutstanding+1)  in-flight count
//   spurious_o        out  1                  1-cycle registered pulse: response dropped, nothing in flight
//   timeout_o         out  1                  1-cycle registered pulse: timeout fired (0 without macro)
// BEHAVIOUR
//   Reset: rr pointer=0, lock clear, FIFO empty, outstanding_o=0, pulses 0; all valid outputs 0.
//   Request path 0-cycle combinational: core_dmi_req_o = ch_req_i[gnt].
//   Arbitration: round-robin from rr pointer over ch_req_valid_i; suppressed (core_dmi_valid_o=0) when FIFO full,
//     even if a pop occurs the same cycle.
//   Lock: core_dmi_valid_o & !core_dmi_ready_i -> gnt registered; no re-arbitration until handshake.
//   ch_req_ready_o[i] = (gnt==i) & core_dmi_ready_i & !full. On handshake: push gnt into ID FIFO, rr = gnt+1 mod NumCh.
//   Response path 0-cycle: head = FIFO head; ch_resp_valid_o[head] = core_dmi_valid_i & !empty; others 0;
//     ch_resp_o[all] = core_dmi_resp_i; core_dmi_ready_o = empty ? 1 : ch_resp_ready_i[head]; pop on handshake.
//   Empty FIFO + core_dmi_valid_i: accept and discard, spurious_o next cycle.
//   Simultaneous push/pop: count unchanged, both pointers advance; wrap by mod MaxOutstanding.
//   Responses strictly in issue order; a channel may have multiple requests in flight.
// CONFIGURATION
//   `DMI_ARB_TIMEOUT_EN defined: counter runs while FIFO non-empty, clears on pop or when empty;
//     at TimeoutCycles-1 head channel gets {data:0, resp:dm::DTM_ERR}, valid held until its ready, then pop;
//     timeout_o pulses; drop counter (width of outstanding_o) increments. While drop>0, core responses
//     are accepted (core_dmi_ready_o=1), discarded, and drop decrements; not forwarded, no spurious_o.
//   Not defined: no counter, no drop logic, waits indefinitely; timeout_o tied 0.
// STRUCTURE
//   dm package: dmi_req_t, dmi_resp_t, DTM_ERR (existing; add nothing parameter-dependent).
//   Channel-ID type and widths are localparams in this module.
//   Sub-module dmi_arb_id_fifo: sync FIFO of channel IDs, Depth/Width params, full/empty/count.
// TESTING
//   NumCh=2, ch0 and ch1 valid same cycle after reset -> ch0 granted first, then ch1; responses
//     0xA,0xB routed to ch0 then ch1.
//   core_dmi_ready_i low 3 cycles with ch1 raising valid mid-stall -> core_dmi_req_o stable, grant unchanged.
//   MaxOutstanding=4, 5 requests, no responses -> 4 accepted, outstanding_o=4, core_dmi_valid_o=0 until 1 response.
//   core_dmi_valid_i with FIFO empty -> core_dmi_ready_o=1, no ch_resp_valid_o, spurious_o pulses once.
//   ch_resp_ready_i[head]=0 for 2 cycles -> core_dmi_ready_o=0, FIFO not popped, response held.
//   With macro, TimeoutCycles=8, no response -> cycle 7 ch gets resp=DTM_ERR, timeout_o; late response dropped.

Source files
------------

// File: rtl/dm.sv
// Debug-module DMI transport types shared by the DTM, CDC and arbitration blocks.
package dm;

  localparam logic [1:0] DTM_NOP     = 2'h0;
  localparam logic [1:0] DTM_READ    = 2'h1;
  localparam logic [1:0] DTM_WRITE   = 2'h2;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_arb_mux_pkg.sv
// Helpers for the DMI channel arbiter/mux.
package dmi_arb_mux_pkg;

  // Channel index reached by stepping 'offset' places past 'base' in an n-entry ring.
  function automatic int unsigned rr_index(input int unsigned base, input int unsigned offset,
                                           input int unsigned n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/dmi_arb_id_fifo.sv
// Synchronous FIFO of channel IDs recording the issue order of in-flight DMI requests.
module dmi_arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmi_arb_mux.sv
// Round-robin arbiter of NumCh DMI masters onto one debug-module port with in-order response routing.
// Optional response timeout with synthesised DTM_ERR responses: define DMI_ARB_TIMEOUT_EN.
module dmi_arb_mux
  import dm::*;
  import dmi_arb_mux_pkg::*;
#(
  parameter int unsigned NumCh          = 2,
  parameter int unsigned MaxOutstanding = 4
`ifdef DMI_ARB_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles = 1024
`endif
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  dmi_req_t  [NumCh-1:0]                 ch_req_i,
  input  logic      [NumCh-1:0]                 ch_req_valid_i,
  output logic      [NumCh-1:0]                 ch_req_ready_o,
  output dmi_resp_t [NumCh-1:0]                 ch_resp_o,
  output logic      [NumCh-1:0]                 ch_resp_valid_o,
  input  logic      [NumCh-1:0]                 ch_resp_ready_i,
  output dmi_req_t                              core_dmi_req_o,
  output logic                                  core_dmi_valid_o,
  input  logic                                  core_dmi_ready_i,
  input  dmi_resp_t                             core_dmi_resp_i,
  input  logic                                  core_dmi_valid_i,
  output logic                                  core_dmi_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  spurious_o,
  output logic                                  timeout_o
);

  localparam int unsigned IdW  = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam dmi_resp_t   ErrResp = '{data: 32'h0, resp: DTM_ERR};

  typedef logic [IdW-1:0] ch_id_t;

  ch_id_t r_rr;
  ch_id_t r_lock_gnt;
  logic   r_lock;
  logic   r_spurious;

  ch_id_t w_arb_gnt;
  logic   w_arb_found;
  ch_id_t w_gnt;
  ch_id_t w_head;
  logic   w_full;
  logic   w_empty;
  logic   w_req_hs;
  logic   w_pop;
  logic   w_spurious;
  logic   w_tmo;
  logic   w_drop_busy;

  // First requesting channel at or after the round-robin pointer.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_gnt   = r_rr;
    for (int unsigned k = 0; k < NumCh; k++) begin
      if (!w_arb_found && ch_req_valid_i[IdW'(rr_index(32'(r_rr), k, NumCh))]) begin
        w_arb_found = 1'b1;
        w_arb_gnt   = IdW'(rr_index(32'(r_rr), k, NumCh));
      end
    end
  end

  assign w_gnt            = r_lock ? r_lock_gnt : w_arb_gnt;
  assign core_dmi_req_o   = ch_req_i[w_gnt];
  assign core_dmi_valid_o = ch_req_valid_i[w_gnt] & ~w_full;
  assign w_req_hs         = core_dmi_valid_o & core_dmi_ready_i;

  always_comb begin
    ch_req_ready_o = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      ch_req_ready_o[i] = (w_gnt == IdW'(i)) & core_dmi_ready_i & ~w_full;
    end
  end

  // Response routing; a timed-out head and pending drops take priority over normal forwarding.
  always_comb begin
    ch_resp_valid_o  = '0;
    core_dmi_ready_o = 1'b1;
    w_pop            = 1'b0;
    w_spurious       = 1'b0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      ch_resp_o[i] = w_tmo ? ErrResp : core_dmi_resp_i;
    end
    if (w_tmo) begin
      ch_resp_valid_o[w_head] = 1'b1;
      core_dmi_ready_o        = w_drop_busy;
      w_pop                   = ch_resp_ready_i[w_head];
    end else if (w_drop_busy) begin
      core_dmi_ready_o = 1'b1;
    end else if (w_empty) begin
      core_dmi_ready_o = 1'b1;
      w_spurious       = core_dmi_valid_i;
    end else begin
      ch_resp_valid_o[w_head] = core_dmi_valid_i;
      core_dmi_ready_o        = ch_resp_ready_i[w_head];
      w_pop                   = core_dmi_valid_i & ch_resp_ready_i[w_head];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_gnt <= '0;
      r_spurious <= 1'b0;
    end else begin
      r_spurious <= w_spurious;
      if (w_req_hs) begin
        r_lock <= 1'b0;
        r_rr   <= IdW'(rr_index(32'(w_gnt), 1, NumCh));
      end else if (core_dmi_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_gnt <= w_gnt;
      end
    end
  end

  assign spurious_o = r_spurious;

  dmi_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_req_hs),
    .data_i  (w_gnt),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (outstanding_o)
  );

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  logic [TmoW-1:0] r_tmo_cnt;
  logic [CntW-1:0] r_drop;
  logic            r_timeout;
  logic            w_drop_dec;

  assign w_tmo       = ~w_empty & (r_tmo_cnt == TmoLast);
  assign w_drop_busy = (r_drop != '0);
  assign w_drop_dec  = w_drop_busy & core_dmi_valid_i;
  assign timeout_o   = r_timeout;

  // Counter saturates at the last cycle so the error response is held until the head accepts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
      r_drop    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_empty || w_pop) r_tmo_cnt <= '0;
      else if (!w_tmo)      r_tmo_cnt <= r_tmo_cnt + 1'b1;
      case ({w_tmo & w_pop, w_drop_dec})
        2'b10:   r_drop <= r_drop + 1'b1;
        2'b01:   r_drop <= r_drop - 1'b1;
        default: r_drop <= r_drop;
      endcase
      r_timeout <= w_tmo & w_pop;
    end
  end
`else
  assign w_tmo       = 1'b0;
  assign w_drop_busy = 1'b0;
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dmi_arb_mux.sv
// Self-checking bench for dmi_arb_mux (NumCh=2, MaxOutstanding=4; TimeoutCycles=8 with DMI_ARB_TIMEOUT_EN).
module tb_dmi_arb_mux;
  import dm::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  dmi_req_t  [1:0]       ch_req_i;
  logic      [1:0]       ch_req_valid_i;
  logic      [1:0]       ch_req_ready_o;
  dmi_resp_t [1:0]       ch_resp_o;
  logic      [1:0]       ch_resp_valid_o;
  logic      [1:0]       ch_resp_ready_i;
  dmi_req_t              core_dmi_req_o;
  logic                  core_dmi_valid_o;
  logic                  core_dmi_ready_i;
  dmi_resp_t             core_dmi_resp_i;
  logic                  core_dmi_valid_i;
  logic                  core_dmi_ready_o;
  logic [2:0]            outstanding_o;
  logic                  spurious_o;
  logic                  timeout_o;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 clk_i = ~clk_i;

  dmi_arb_mux #(
    .NumCh          (2),
    .MaxOutstanding (4)
`ifdef DMI_ARB_TIMEOUT_EN
    , .TimeoutCycles (8)
`endif
  ) u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ch_req_i         (ch_req_i),
    .ch_req_valid_i   (ch_req_valid_i),
    .ch_req_ready_o   (ch_req_ready_o),
    .ch_resp_o        (ch_resp_o),
    .ch_resp_valid_o  (ch_resp_valid_o),
    .ch_resp_ready_i  (ch_resp_ready_i),
    .core_dmi_req_o   (core_dmi_req_o),
    .core_dmi_valid_o (core_dmi_valid_o),
    .core_dmi_ready_i (core_dmi_ready_i),
    .core_dmi_resp_i  (core_dmi_resp_i),
    .core_dmi_valid_i (core_dmi_valid_i),
    .core_dmi_ready_o (core_dmi_ready_o),
    .outstanding_o    (outstanding_o),
    .spurious_o       (spurious_o),
    .timeout_o        (timeout_o)
  );

  typedef struct {
    logic [1:0] vin;
    logic       rdy;
    logic       rsp_v;
    logic       exp_cv;
    logic [6:0] exp_addr;
    logic [1:0] exp_rdy;
    logic       exp_cdro;
    logic [1:0] exp_crv;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one core response and compare its routing against the scoreboard head.
  task automatic resp_drive(input logic [31:0] data, input string name);
    logic ch;
    core_dmi_resp_i  = '{data: data, resp: DTM_SUCCESS};
    core_dmi_valid_i = 1'b1;
    #2;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, resp_valid=0x%0h", name, ch_resp_valid_o);
    end else begin
      ch = exp_q.pop_front();
      chk({name, "_valid"}, 64'(ch_resp_valid_o), 64'(2'b01 << ch));
      chk({name, "_data"}, 64'(ch_resp_o[ch].data), 64'(data));
      chk({name, "_ready"}, 64'(core_dmi_ready_o), 64'd1);
    end
  endtask

  task automatic resp_check(input logic [31:0] data, input string name);
    resp_drive(data, name);
    tick();
    core_dmi_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ch_req_i[0]      = '{addr: 7'h10, op: DTM_READ,  data: 32'h0000_1000};
    ch_req_i[1]      = '{addr: 7'h21, op: DTM_WRITE, data: 32'h0000_2100};
    ch_req_valid_i   = 2'b00;
    ch_resp_ready_i  = 2'b11;
    core_dmi_ready_i = 1'b1;
    core_dmi_resp_i  = '0;
    core_dmi_valid_i = 1'b0;

    // Combinational vectors applied while reset holds rr=0, no lock, FIFO empty.
    vecs[0] = '{2'b00, 1'b1, 1'b0, 1'b0, 7'h10, 2'b01, 1'b1, 2'b00};
    vecs[1] = '{2'b01, 1'b1, 1'b0, 1'b1, 7'h10, 2'b01, 1'b1, 2'b00};
    vecs[2] = '{2'b10, 1'b1, 1'b0, 1'b1, 7'h21, 2'b10, 1'b1, 2'b00};
    vecs[3] = '{2'b11, 1'b1, 1'b0, 1'b1, 7'h10, 2'b01, 1'b1, 2'b00};
    vecs[4] = '{2'b10, 1'b0, 1'b0, 1'b1, 7'h21, 2'b00, 1'b1, 2'b00};
    vecs[5] = '{2'b11, 1'b0, 1'b0, 1'b1, 7'h10, 2'b00, 1'b1, 2'b00};
    vecs[6] = '{2'b01, 1'b1, 1'b1, 1'b1, 7'h10, 2'b01, 1'b1, 2'b00};
    vecs[7] = '{2'b10, 1'b0, 1'b1, 1'b1, 7'h21, 2'b00, 1'b1, 2'b00};

    #1;
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_spurious", 64'(spurious_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_core_valid", 64'(core_dmi_valid_o), 64'd0);
    chk("rst_resp_valid", 64'(ch_resp_valid_o), 64'd0);

    for (int v = 0; v < 8; v++) begin
      ch_req_valid_i   = vecs[v].vin;
      core_dmi_ready_i = vecs[v].rdy;
      core_dmi_valid_i = vecs[v].rsp_v;
      #1;
      chk($sformatf("vec%0d_core_valid", v), 64'(core_dmi_valid_o), 64'(vecs[v].exp_cv));
      chk($sformatf("vec%0d_addr", v), 64'(core_dmi_req_o.addr), 64'(vecs[v].exp_addr));
      chk($sformatf("vec%0d_req_ready", v), 64'(ch_req_ready_o), 64'(vecs[v].exp_rdy));
      chk($sformatf("vec%0d_core_ready", v), 64'(core_dmi_ready_o), 64'(vecs[v].exp_cdro));
      chk($sformatf("vec%0d_resp_valid", v), 64'(ch_resp_valid_o), 64'(vecs[v].exp_crv));
    end
    ch_req_valid_i   = 2'b00;
    core_dmi_ready_i = 1'b1;
    core_dmi_valid_i = 1'b0;

    tick();
    rst_i = 1'b0;
    #2;
    chk("post_rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("post_rst_spurious", 64'(spurious_o), 64'd0);
    tick();

    // Both channels request together: ch0 first, then ch1.
    ch_req_valid_i = 2'b11;
    #2;
    chk("rr_first_addr", 64'(core_dmi_req_o.addr), 64'h10);
    chk("rr_first_ready", 64'(ch_req_ready_o), 64'b01);
    exp_q.push_back(1'b0);
    tick();
    ch_req_valid_i = 2'b10;
    #2;
    chk("rr_second_addr", 64'(core_dmi_req_o.addr), 64'h21);
    chk("rr_second_ready", 64'(ch_req_ready_o), 64'b10);
    exp_q.push_back(1'b1);
    tick();
    ch_req_valid_i = 2'b00;
    chk("rr_outstanding", 64'(outstanding_o), 64'd2);
    resp_check(32'hA, "resp_a");
    resp_check(32'hB, "resp_b");
    chk("rr_drained", 64'(outstanding_o), 64'd0);

    // Stall with ch1 granted; ch0 arriving mid-stall must not steal the grant.
    core_dmi_ready_i = 1'b0;
    ch_req_valid_i   = 2'b10;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) ch_req_valid_i = 2'b11;
      #2;
      chk($sformatf("stall%0d_addr", c), 64'(core_dmi_req_o.addr), 64'h21);
      chk($sformatf("stall%0d_valid", c), 64'(core_dmi_valid_o), 64'd1);
      chk($sformatf("stall%0d_req_ready", c), 64'(ch_req_ready_o), 64'b00);
      tick();
    end
    core_dmi_ready_i = 1'b1;
    #2;
    chk("stall_release_addr", 64'(core_dmi_req_o.addr), 64'h21);
    chk("stall_release_ready", 64'(ch_req_ready_o), 64'b10);
    exp_q.push_back(1'b1);
    tick();
    ch_req_valid_i = 2'b01;
    #2;
    chk("stall_next_addr", 64'(core_dmi_req_o.addr), 64'h10);
    exp_q.push_back(1'b0);
    tick();
    ch_req_valid_i = 2'b00;
    resp_check(32'h1, "stall_resp1");
    resp_check(32'h2, "stall_resp0");

    // Fill the ID FIFO: five requests, four accepted.
    begin
      int model_cnt;
      logic exp_v;
      model_cnt      = 0;
      ch_req_valid_i = 2'b01;
      for (int c = 0; c < 6; c++) begin
        #2;
        exp_v = (model_cnt < 4);
        chk($sformatf("fill%0d_core_valid", c), 64'(core_dmi_valid_o), 64'(exp_v));
        if (exp_v) begin
          exp_q.push_back(1'b0);
          model_cnt++;
        end
        tick();
      end
      chk("full_outstanding", 64'(outstanding_o), 64'd4);
      chk("full_req_ready", 64'(ch_req_ready_o), 64'b00);
      resp_drive(32'hC0, "full_pop");
      chk("full_pop_core_valid", 64'(core_dmi_valid_o), 64'd0);
      tick();
      core_dmi_valid_i = 1'b0;
      chk("after_pop_outstanding", 64'(outstanding_o), 64'd3);
      #2;
      chk("after_pop_core_valid", 64'(core_dmi_valid_o), 64'd1);
      exp_q.push_back(1'b0);
      tick();
      ch_req_valid_i = 2'b00;
      chk("refill_outstanding", 64'(outstanding_o), 64'd4);
      for (int c = 0; c < 4; c++) resp_check(32'hC1 + 32'(c), $sformatf("drain%0d", c));
      chk("drained_outstanding", 64'(outstanding_o), 64'd0);
    end

    // Response with nothing in flight.
    core_dmi_resp_i  = '{data: 32'h77, resp: DTM_SUCCESS};
    core_dmi_valid_i = 1'b1;
    #2;
    chk("spur_core_ready", 64'(core_dmi_ready_o), 64'd1);
    chk("spur_resp_valid", 64'(ch_resp_valid_o), 64'b00);
    chk("spur_pulse_before", 64'(spurious_o), 64'd0);
    tick();
    core_dmi_valid_i = 1'b0;
    #2;
    chk("spur_pulse", 64'(spurious_o), 64'd1);
    tick();
    chk("spur_pulse_end", 64'(spurious_o), 64'd0);

    // Channel back-pressure holds the response in place.
    ch_req_valid_i = 2'b10;
    #2;
    chk("bp_req_addr", 64'(core_dmi_req_o.addr), 64'h21);
    exp_q.push_back(1'b1);
    tick();
    ch_req_valid_i   = 2'b00;
    ch_resp_ready_i  = 2'b00;
    core_dmi_resp_i  = '{data: 32'hD0, resp: DTM_SUCCESS};
    core_dmi_valid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk($sformatf("bp%0d_resp_valid", c), 64'(ch_resp_valid_o), 64'b10);
      chk($sformatf("bp%0d_core_ready", c), 64'(core_dmi_ready_o), 64'd0);
      chk($sformatf("bp%0d_outstanding", c), 64'(outstanding_o), 64'd1);
      tick();
    end
    ch_resp_ready_i = 2'b11;
    resp_check(32'hD0, "bp_release");
    chk("bp_outstanding", 64'(outstanding_o), 64'd0);

`ifdef DMI_ARB_TIMEOUT_EN
    // Unanswered request: synthesised error after TimeoutCycles-1, late response dropped.
    begin
      int   k;
      logic found;
      ch_req_valid_i = 2'b01;
      #2;
      chk("tmo_req_valid", 64'(core_dmi_valid_o), 64'd1);
      tick();
      ch_req_valid_i = 2'b00;
      k     = 0;
      found = 1'b0;
      while (k < 20 && !found) begin
        #2;
        if (ch_resp_valid_o[0]) found = 1'b1;
        else begin
          tick();
          k++;
        end
      end
      chk("tmo_found", 64'(found), 64'd1);
      chk("tmo_cycle", 64'(k), 64'd7);
      chk("tmo_resp_code", 64'(ch_resp_o[0].resp), 64'(DTM_ERR));
      chk("tmo_resp_data", 64'(ch_resp_o[0].data), 64'd0);
      chk("tmo_core_ready", 64'(core_dmi_ready_o), 64'd0);
      tick();
      chk("tmo_pulse", 64'(timeout_o), 64'd1);
      chk("tmo_outstanding", 64'(outstanding_o), 64'd0);
      core_dmi_resp_i  = '{data: 32'h55, resp: DTM_SUCCESS};
      core_dmi_valid_i = 1'b1;
      #2;
      chk("late_core_ready", 64'(core_dmi_ready_o), 64'd1);
      chk("late_resp_valid", 64'(ch_resp_valid_o), 64'b00);
      tick();
      core_dmi_valid_i = 1'b0;
      #2;
      chk("late_no_spurious", 64'(spurious_o), 64'd0);
      chk("tmo_pulse_end", 64'(timeout_o), 64'd0);
      tick();
    end
`else
    chk("no_tmo_timeout", 64'(timeout_o), 64'd0);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
